// File: rtl/readout_pkg.sv
// Shared types and helpers for the pixel readout path: count width, scanner
// states and the Gray-to-binary conversion used by the ramp-counter variant.
package readout_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  // Each binary bit is the XOR of itself and every more-significant Gray bit.
  function automatic logic [COUNT_W-1:0] gray2bin(input logic [COUNT_W-1:0] g);
    logic [COUNT_W-1:0] b;
    b[COUNT_W-1] = g[COUNT_W-1];
    for (int i = COUNT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_readout_scanner_if.sv
// Valid/ready beat stream carrying one pixel count plus its index and
// first/last framing from the scanner to the readout link.
interface pixel_readout_scanner_if
  import readout_pkg::*;
#(
  parameter int IDX_W = 3
) ();

  logic               out_valid;
  logic               out_ready;
  logic [COUNT_W-1:0] out_data;
  logic [IDX_W-1:0]   out_index;
  logic               out_first;
  logic               out_last;

  modport master (
    output out_valid, out_data, out_index, out_first, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_first, out_last,
    output out_ready
  );

endinterface

// File: rtl/pixel_readout_scanner.sv
// Snapshots the per-pixel count registers on start and streams them out one
// beat per pixel. Build with GRAY_DECODE_EN to decode Gray-coded counts.
module pixel_readout_scanner
  import readout_pkg::*;
#(
  parameter int NUM_PIXELS = 5,
  parameter int IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [NUM_PIXELS-1:0][COUNT_W-1:0]   stored_values,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 overrun,
  pixel_readout_scanner_if.master              out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               overrun_q, overrun_d;
  logic               load;
  logic               handshake;
  logic [COUNT_W-1:0] snap_q [NUM_PIXELS];
  logic [COUNT_W-1:0] snap_word;

  // Copying the whole array at once frees the register array for the next
  // conversion right away.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (reset) begin
        snap_q[i] <= '0;
      end else if (load) begin
        snap_q[i] <= stored_values[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign handshake = out.out_valid & out.out_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          ptr_d   = '0;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (start) overrun_d = 1'b1;
        if (handshake) begin
          if (ptr_q == LAST_IDX) state_d = DONE;
          else                   ptr_d   = ptr_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (start) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign snap_word = snap_q[ptr_q];

`ifdef GRAY_DECODE_EN
  assign out.out_data = gray2bin(snap_word);
`else
  assign out.out_data = snap_word;
`endif

  assign out.out_valid = (state_q == SEND);
  assign out.out_index = ptr_q;
  // Framing is qualified by valid so both flags read 0 outside a frame.
  assign out.out_first = (state_q == SEND) && (ptr_q == '0);
  assign out.out_last  = (state_q == SEND) && (ptr_q == LAST_IDX);

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pixel_readout_scanner.sv
// Directed bench for pixel_readout_scanner: a queue-based frame model checked
// every cycle, plus literal expectations for latency, order and framing.
module tb_pixel_readout_scanner;

  localparam int N  = 5;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [N-1:0][7:0] stored = '0;
  logic              busy, frame_done, overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_readout_scanner_if #(.IDX_W(IW)) bus ();

  pixel_readout_scanner #(.NUM_PIXELS(N), .IDX_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stored_values (stored),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .out           (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Binary bit i of a Gray word is the parity of bits i and above.
  function automatic logic [7:0] expect_byte(input logic [7:0] raw);
    logic [7:0] b;
    b = raw;
`ifdef GRAY_DECODE_EN
    for (int i = 0; i < 8; i++) b[i] = ^(raw >> i);
`endif
    return b;
  endfunction

  // Model: a frame is the queue of beats still owed; done is the pulse cycle.
  logic [7:0] mq_data[$];
  int         mq_idx[$];
  bit         m_done = 1'b0;
  bit         m_ovr  = 1'b0;
  bit         m_was_send, m_was_done;
  bit         run_cmp = 1'b0;

  always @(posedge clk) begin
    m_was_send = (mq_data.size() > 0);
    m_was_done = m_done;
    if (reset) begin
      mq_data.delete();
      mq_idx.delete();
      m_done = 1'b0;
      m_ovr  = 1'b0;
    end else if (!m_was_send && !m_was_done) begin
      if (start) begin
        for (int i = 0; i < N; i++) begin
          mq_data.push_back(expect_byte(stored[i]));
          mq_idx.push_back(i);
        end
      end
    end else begin
      if (start) m_ovr = 1'b1;
      m_done = 1'b0;
      if (m_was_send && bus.out_ready) begin
        void'(mq_data.pop_front());
        void'(mq_idx.pop_front());
        if (mq_data.size() == 0) m_done = 1'b1;
      end
    end
  end

  logic [7:0] acc_data[$];
  int         acc_idx[$];

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("out_valid", bus.out_valid, mq_data.size() > 0);
      chk("busy", busy, (mq_data.size() > 0) || m_done);
      chk("frame_done", frame_done, m_done);
      chk("overrun", overrun, m_ovr);
      if (mq_data.size() > 0 && bus.out_valid === 1'b1) begin
        chk("out_data", bus.out_data, mq_data[0]);
        chk("out_index", bus.out_index, mq_idx[0]);
        chk("out_first", bus.out_first, mq_idx[0] == 0);
        chk("out_last", bus.out_last, mq_idx[0] == N - 1);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && !reset) begin
        acc_data.push_back(bus.out_data);
        acc_idx.push_back(int'(bus.out_index));
        $display("beat idx=%0d data=0x%02h first=%0b last=%0b",
                 bus.out_index, bus.out_data, bus.out_first, bus.out_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts negedges from the current cycle until frame_done, then realigns.
  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_done === 1'b1) break;
      if (cyc >= budget) begin
        checks++;
        failures++;
        $display("FAIL %s: no frame_done within %0d cycles", name, budget);
        break;
      end
    end
    tick();
  endtask

  task automatic check_order(input string name, input logic [7:0] exp_data[N]);
    chk({name, "_count"}, acc_data.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < acc_data.size()) begin
        chk({name, "_data"}, acc_data[i], exp_data[i]);
        chk({name, "_index"}, acc_idx[i], i);
      end
    end
  endtask

  initial begin
    int         cyc;
    int         pat[4] = '{1, 0, 0, 1};
    logic [7:0] base[N] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    logic [7:0] gray_exp;

    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_done", frame_done, 0);
    tick();

    // Basic frame with ready held high.
    for (int i = 0; i < N; i++) stored[i] = base[i];
    bus.out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1);
    chk("latency_index", bus.out_index, 0);
    chk("latency_first", bus.out_first, 1);
    wait_done("basic_done", 50, cyc);
    chk("basic_frame_len", cyc + 1, N + 1);
    check_order("basic", base);

    // Backpressure, snapshot isolation and overrun within one frame.
    acc_data.delete();
    acc_idx.delete();
    pulse_start();
    stored = '1;
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      bus.out_ready = pat[k % 4][0];
      start = (k == 3);
      @(negedge clk);
      cyc++;
      if (frame_done === 1'b1) break;
      tick();
    end
    start = 1'b0;
    chk("bp_finished", frame_done, 1);
    check_order("bp", base);
    chk("bp_overrun_set", overrun, 1);

    // Start in the IDLE cycle right after frame_done, then reset mid-frame.
    tick();
    for (int i = 0; i < N; i++) stored[i] = 8'(i + 7);
    acc_data.delete();
    acc_idx.delete();
    bus.out_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 20 && acc_data.size() < 3; k++) tick();
    chk("mid_beats", acc_data.size(), 3);
    chk("mid_first_data", acc_data[0], expect_byte(8'd7));
    chk("mid_overrun_sticky", overrun, 1);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_done", frame_done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("abort_no_done", frame_done, 0);
    end
    tick();

    // Fresh full frame; pixel 0 carries a Gray-coded pattern.
    stored[0] = 8'hC0;
    for (int i = 1; i < N; i++) stored[i] = 8'(i);
`ifdef GRAY_DECODE_EN
    gray_exp = 8'h80;
`else
    gray_exp = 8'hC0;
`endif
    acc_data.delete();
    acc_idx.delete();
    bus.out_ready = 1'b1;
    pulse_start();
    wait_done("fresh_done", 50, cyc);
    chk("fresh_frame_len", cyc, N + 1);
    chk("fresh_count", acc_data.size(), N);
    if (acc_data.size() > 0) chk("gray_pixel0", acc_data[0], gray_exp);
    chk("fresh_overrun", overrun, 0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_readout_scanner.md
Name: pixel_readout_scanner

Overview:
Reader side of the per-pixel register array in the single-slope ADC column. On `start`, it snapshots all NUM_PIXELS stored 8-bit counts, so the next conversion may begin immediately. It then streams the snapshot out one pixel per beat over a valid/ready interface, with first/last framing and a pixel index. It sits between the register array and the readout/serial link.

Parameters:
- NUM_PIXELS, default 5: number of pixels scanned per frame; must be ≥1.
- IDX_W, default $clog2(NUM_PIXELS) with a minimum of 1: width of out_index.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  single-cycle request to snapshot and read out one frame
- stored_values  input  [NUM_PIXELS-1:0][7:0]  count values from the register array
- busy  output  1  high whenever state != IDLE
- out_valid  output  1  beat available
- out_ready  input  1  downstream accepts the beat
- out_data  output  8  pixel count (binary)
- out_index  output  IDX_W  pixel number of the current beat, 0..NUM_PIXELS-1
- out_first  output  1  high on the beat with index 0
- out_last  output  1  high on the beat with index NUM_PIXELS-1
- frame_done  output  1  one-cycle pulse after the last beat is accepted
- overrun  output  1  sticky: start arrived while not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, snapshot contents don't-care (cleared to 0). Reset mid-frame aborts at once; the next cycle has out_valid=0 and no frame_done.
- States:
  - IDLE → SEND on start. At that edge, stored_values is copied into the internal snapshot and the pointer is set to 0.
  - SEND → SEND on handshake (out_valid & out_ready) with pointer < NUM_PIXELS-1; the pointer increments.
  - SEND → DONE on handshake with pointer == NUM_PIXELS-1.
  - DONE → IDLE unconditionally after 1 cycle; frame_done=1 only in DONE.
- Latency: start sampled at edge T; out_valid=1 with index 0 in the cycle after T. Minimum frame length is NUM_PIXELS+1 cycles from start to frame_done, given out_ready held at 1.
- Handshake: out_valid is high in SEND only. While out_valid & !out_ready, out_data, out_index, out_first and out_last hold stable. out_valid never drops without a handshake, except on reset.
- out_data = snapshot[pointer]. Later changes on stored_values never affect an in-flight frame.
- NUM_PIXELS=1: the single beat has out_first=out_last=1.
- start while busy (SEND or DONE): ignored, and overrun is set to 1. overrun stays set until reset.
- start in IDLE in the same cycle that frame_done was pulsed the previous cycle: legal and accepted.
- The pointer never wraps. It is only reloaded on entry to SEND.

Optional Feature:
- Macro GRAY_DECODE_EN.
- When defined, stored values are Gray-coded (Gray ramp counter). Each snapshot entry is converted to binary before out_data, using bin[7]=g[7] and bin[i]=bin[i+1]^g[i]. The conversion is combinational on the snapshot output and adds no latency.
- When undefined, out_data is the raw snapshot byte.

Decomposition:
- Shared package readout_pkg:
  - COUNT_W=8
  - state enum {IDLE, SEND, DONE}
  - function gray2bin(COUNT_W)
- No sub-module: the snapshot, FSM and pointer all live in one module.

Test Plan:
- Basic frame: stored={10,20,30,40,50} (index 0..4), out_ready=1, pulse start → beats 10,20,30,40,50 with index 0..4 on consecutive cycles; first on beat 0, last on beat 4; frame_done pulses one cycle after beat 4.
- Backpressure: same data, out_ready toggling 1,0,0,1… → each beat holds data/index/first/last stable while ready=0; no beat lost or duplicated; output order unchanged.
- Snapshot isolation: after start, change stored_values to all 8'hFF → streamed data is still 10..50.
- Overrun: pulse start again during SEND → ignored, frame continues unchanged, overrun=1 and remains 1 until reset.
- Reset mid-frame: assert reset after beat 2 → next cycle out_valid=0, busy=0, overrun=0, no frame_done. A following start streams a full fresh frame.
- GRAY_DECODE_EN defined: stored[0]=8'b1100_0000 (Gray) → out_data=8'b1000_0000 (128). Without the macro → 8'hC0.
